// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame pulses and the frame IRQ flag, advanced by CPU-cycle strobes.
// Latency: pulses are registered and appear one clk after the cpu_ce that caused them; irq/mode are register levels.
// No backpressure: all state moves only on cpu_ce; a $4017 write restarts the sequence after a 3/4-cycle delay.
module apu_frame_counter #(
  parameter int unsigned STEP1 = 7457,
  parameter int unsigned STEP2 = 14913,
  parameter int unsigned STEP3 = 22371,
  parameter int unsigned STEP4 = 29829,
  parameter int unsigned STEP5 = 37281
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [1:0] wr_data,
  input  logic       irq_clr,
  output logic       quarterframe,
  output logic       halfframe,
  output logic       frame_irq,
  output logic       mode
);

  localparam logic [15:0] C_S1  = 16'(STEP1);
  localparam logic [15:0] C_S2  = 16'(STEP2);
  localparam logic [15:0] C_S3  = 16'(STEP3);
  localparam logic [15:0] C_S4M = 16'(STEP4 - 1);
  localparam logic [15:0] C_S4  = 16'(STEP4);
  localparam logic [15:0] C_S4P = 16'(STEP4 + 1);
  localparam logic [15:0] C_S5  = 16'(STEP5);
  localparam logic [15:0] C_S5P = 16'(STEP5 + 1);

  logic [15:0] cnt;
  logic        inhibit;
  logic        cyc_odd;
  logic        pending;
  logic [2:0]  dly;

  logic ev_q;
  logic ev_h;
  logic ev_irq;
  logic ev_wrap;
  logic dly_fire;

  // Decode count-based sequencer events from the pre-increment count and the current mode
  always_comb begin
    ev_q    = 1'b0;
    ev_h    = 1'b0;
    ev_irq  = 1'b0;
    ev_wrap = 1'b0;
    if (!mode) begin
      if (cnt == C_S1 || cnt == C_S3) ev_q = 1'b1;
      if (cnt == C_S2 || cnt == C_S4) begin
        ev_q = 1'b1;
        ev_h = 1'b1;
      end
      if (cnt == C_S4M || cnt == C_S4 || cnt == C_S4P) ev_irq = 1'b1;
      if (cnt == C_S4P) ev_wrap = 1'b1;
    end else begin
      if (cnt == C_S1 || cnt == C_S3) ev_q = 1'b1;
      if (cnt == C_S2 || cnt == C_S5) begin
        ev_q = 1'b1;
        ev_h = 1'b1;
      end
      if (cnt == C_S5P) ev_wrap = 1'b1;
    end
  end

  // A fresh write restarts the delay, so it also cancels a reset that would fire this cycle
  assign dly_fire = pending && (dly == 3'd1) && !wr_4017;

  // Sequencer state, pulse outputs, IRQ flag and the $4017 delayed-reset machinery
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 16'd0;
      mode         <= 1'b0;
      inhibit      <= 1'b0;
      cyc_odd      <= 1'b0;
      pending      <= 1'b0;
      dly          <= 3'd0;
      quarterframe <= 1'b0;
      halfframe    <= 1'b0;
      frame_irq    <= 1'b0;
    end else begin
      quarterframe <= 1'b0;
      halfframe    <= 1'b0;
      if (cpu_ce) begin
        cyc_odd <= ~cyc_odd;

        // Delayed reset takes over the count and replaces count-based events;
        // in 5-step mode it clocks the units immediately.
        if (dly_fire) begin
          cnt          <= 16'd0;
          quarterframe <= mode;
          halfframe    <= mode;
        end else begin
          cnt          <= ev_wrap ? 16'd0 : cnt + 16'd1;
          quarterframe <= ev_q;
          halfframe    <= ev_h;
        end

        // Inhibiting write clears outright; otherwise a set beats an acknowledge
        if (wr_4017 && wr_data[0]) begin
          frame_irq <= 1'b0;
        end else if (!dly_fire && ev_irq && !inhibit) begin
          frame_irq <= 1'b1;
        end else if (irq_clr) begin
          frame_irq <= 1'b0;
        end

        if (wr_4017) begin
          mode    <= wr_data[1];
          inhibit <= wr_data[0];
          pending <= 1'b1;
          dly     <= cyc_odd ? 3'd4 : 3'd3;
        end else if (pending) begin
          if (dly == 3'd1) pending <= 1'b0;
          dly <= dly - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_frame_counter.sv
// Testbench for apu_frame_counter: directed frame sequences plus randomized strobes/writes/acks/resets.
// Expected outputs come from a table-driven frame model stepped once per clk.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_apu_frame_counter;

  localparam int S1 = 23;
  localparam int S2 = 47;
  localparam int S3 = 71;
  localparam int S4 = 95;
  localparam int S5 = 119;
  localparam int END0 = S4 + 1;
  localparam int END1 = S5 + 1;

  // Event tables: {quarter, half, irq} per frame position
  localparam int       EV0_POS [6] = '{S1, S2, S3, S4 - 1, S4, S4 + 1};
  localparam bit [2:0] EV0_K   [6] = '{3'b100, 3'b110, 3'b100, 3'b001, 3'b111, 3'b001};
  localparam int       EV1_POS [4] = '{S1, S2, S3, S5};
  localparam bit [2:0] EV1_K   [4] = '{3'b100, 3'b110, 3'b100, 3'b110};

  logic       clk;
  logic       rst;
  logic       cpu_ce;
  logic       wr_4017;
  logic [1:0] wr_data;
  logic       irq_clr;
  logic       quarterframe;
  logic       halfframe;
  logic       frame_irq;
  logic       mode;

  int n_checks;
  int n_fail;
  int q_seen;
  int h_seen;

  // Reference model state
  int m_pos;
  bit m_mode;
  bit m_inh;
  bit m_irq;
  bit m_par;
  int m_rem;
  bit e_q;
  bit e_h;

  apu_frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_ce(cpu_ce),
    .wr_4017(wr_4017),
    .wr_data(wr_data),
    .irq_clr(irq_clr),
    .quarterframe(quarterframe),
    .halfframe(halfframe),
    .frame_irq(frame_irq),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void lookup(input bit m, input int p, output bit q, output bit h, output bit i);
    q = 1'b0;
    h = 1'b0;
    i = 1'b0;
    if (!m) begin
      for (int k = 0; k < 6; k++)
        if (p == EV0_POS[k]) begin
          q = EV0_K[k][2];
          h = EV0_K[k][1];
          i = EV0_K[k][0];
        end
    end else begin
      for (int k = 0; k < 4; k++)
        if (p == EV1_POS[k]) begin
          q = EV1_K[k][2];
          h = EV1_K[k][1];
          i = EV1_K[k][0];
        end
    end
  endfunction

  // True when a write at the current position is free of coincident events
  function automatic bit quiet(input int ahead);
    bit q, h, i;
    lookup(m_mode, m_pos + ahead, q, h, i);
    return !(q | h | i) && (m_rem != 1) && (m_pos + ahead != END0) && (m_pos + ahead != END1);
  endfunction

  task automatic model_step(input bit ce, input bit wr, input bit [1:0] d, input bit clr, input bit r);
    bit q, h, i, fire;
    e_q = 1'b0;
    e_h = 1'b0;
    if (r) begin
      m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_par = 0; m_rem = 0;
      return;
    end
    if (!ce) return;
    fire = (m_rem == 1) && !wr;
    i = 1'b0;
    if (fire) begin
      e_q = m_mode;
      e_h = m_mode;
      m_pos = 0;
    end else begin
      lookup(m_mode, m_pos, q, h, i);
      e_q = q;
      e_h = h;
      m_pos = (m_pos == (m_mode ? END1 : END0)) ? 0 : (m_pos + 1) % 65536;
    end
    if (wr && d[0]) m_irq = 1'b0;
    else if (i && !m_inh) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    if (wr) begin
      m_mode = d[1];
      m_inh  = d[0];
      m_rem  = m_par ? 4 : 3;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    m_par = !m_par;
  endtask

  task automatic tick(input bit ce, input bit wr, input bit [1:0] d, input bit clr, input bit r);
    cpu_ce  = ce;
    wr_4017 = wr;
    wr_data = d;
    irq_clr = clr;
    rst     = r;
    @(posedge clk);
    model_step(ce, wr, d, clr, r);
    #1;
    check_eq("quarterframe", quarterframe, e_q);
    check_eq("halfframe", halfframe, e_h);
    check_eq("frame_irq", frame_irq, m_irq);
    check_eq("mode", mode, m_mode);
    if (quarterframe) q_seen++;
    if (halfframe) h_seen++;
  endtask

  // Advance with cpu_ce until a quiet write slot with the wanted parity (and quiet next slot)
  task automatic seek(input bit want_par, input string tag);
    int budget;
    budget = 400;
    while (!(quiet(0) && quiet(1) && m_par == want_par) && budget > 0) begin
      tick(1, 0, 2'b00, 0, 0);
      budget--;
    end
    if (budget == 0) check_eq({tag, "_seek_timeout"}, 0, 1);
  endtask

  initial begin
    int idx;
    bit par2;
    n_checks = 0; n_fail = 0; q_seen = 0; h_seen = 0;
    cpu_ce = 0; wr_4017 = 0; wr_data = 2'b00; irq_clr = 0; rst = 1;

    // Reset, including strobes and a write while held in reset
    repeat (3) tick(0, 0, 2'b00, 0, 1);
    tick(1, 1, 2'b11, 1, 1);
    tick(1, 0, 2'b00, 0, 1);
    check_eq("reset_outputs", {quarterframe, halfframe, frame_irq, mode}, 0);
    tick(0, 0, 2'b00, 0, 0);

    // 4-step frame 1: ack coincident with the STEP4 set must lose
    q_seen = 0; h_seen = 0;
    for (int n = 0; n < END0 + 1; n++) begin
      tick(1, 0, 2'b00, (m_pos == S4), 0);
      if (n == S4) check_eq("irq_set_beats_clr", frame_irq, 1);
    end
    check_eq("frame0_q_count", q_seen, 4);
    check_eq("frame0_h_count", h_seen, 2);
    check_eq("frame0_irq_high", frame_irq, 1);

    // Frame 2: plain ack clears, then inhibiting write coincident with a set clears
    for (int n = 0; n < 200 && m_pos != S4; n++) begin
      tick(1, 0, 2'b00, (m_pos == 10), 0);
      if (m_pos == 11) check_eq("irq_clr_clears", frame_irq, 0);
    end
    tick(1, 1, 2'b01, 0, 0);
    check_eq("inhibit_write_clears", frame_irq, 0);
    q_seen = 0; h_seen = 0;
    for (int n = 0; n < END0 + 6; n++) tick(1, 0, 2'b00, 0, 0);
    check_eq("inhibited_irq_low", frame_irq, 0);
    check_eq("inhibited_q_count", q_seen, 4);

    // Switch to 5-step with even parity: Q+H three strobes later, then a full frame
    seek(1'b0, "even");
    tick(1, 1, 2'b10, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    check_eq("even_write_qh_at_3", {quarterframe, halfframe}, 3);
    q_seen = 0; h_seen = 0;
    for (int n = 0; n < END1 + 1; n++) tick(1, 0, 2'b00, 0, 0);
    check_eq("frame1_q_count", q_seen, 4);
    check_eq("frame1_h_count", h_seen, 2);
    check_eq("frame1_irq_low", frame_irq, 0);

    // Odd parity: four strobes, with an idle clk mixed in
    seek(1'b1, "odd");
    tick(1, 1, 2'b10, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    tick(0, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    check_eq("odd_write_no_qh_at_3", {quarterframe, halfframe}, 0);
    tick(1, 0, 2'b00, 0, 0);
    check_eq("odd_write_qh_at_4", {quarterframe, halfframe}, 3);

    // Second write while pending restarts the delay from the second write
    seek(1'b0, "rewrite");
    tick(1, 1, 2'b10, 0, 0);
    par2 = m_par;
    tick(1, 1, 2'b10, 0, 0);
    idx = 0;
    for (int n = 1; n <= 6; n++) begin
      tick(1, 0, 2'b00, 0, 0);
      if (quarterframe && idx == 0) idx = n;
    end
    check_eq("rewrite_delay", idx, par2 ? 4 : 3);

    // Reset while dly=2 drops the pending Q+H
    seek(1'b0, "rstpend");
    tick(1, 1, 2'b10, 0, 0);
    for (int n = 0; n < 4 && m_rem != 2; n++) tick(1, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 1);
    check_eq("rst_pending_outputs", {quarterframe, halfframe, frame_irq, mode}, 0);
    q_seen = 0;
    for (int n = 0; n < S1; n++) tick(1, 0, 2'b00, 0, 0);
    check_eq("rst_pending_no_pulse", q_seen, 0);
    tick(1, 0, 2'b00, 0, 0);
    check_eq("rst_restart_first_q", quarterframe, 1);

    // Randomized strobes, writes, acks and occasional resets
    for (int n = 0; n < 4000; n++) begin
      bit ce_r, wr_r, clr_r, rst_r;
      bit [1:0] d_r;
      ce_r  = ($urandom_range(3) != 0);
      rst_r = ($urandom_range(999) == 0);
      wr_r  = ce_r && quiet(0) && ($urandom_range(60) == 0);
      d_r   = 2'($urandom_range(3));
      clr_r = ce_r && ($urandom_range(15) == 0);
      tick(ce_r, wr_r, d_r, clr_r, rst_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
